// File: rtl/red_pitaya_lock_ctrl_if.sv
// ----------------------------------------------------------------------------
// red_pitaya_lock_ctrl_if : settings bus for the lock-acquisition sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface red_pitaya_lock_ctrl_if #(
    parameter int DW = 14,
    parameter int CW = 24
);
    logic signed [DW-1:0] set_lo;
    logic signed [DW-1:0] set_hi;
    logic signed [DW-1:0] set_min;
    logic signed [DW-1:0] set_max;
    logic        [DW-1:0] set_step;
    logic        [CW-1:0] set_div;
    logic        [CW-1:0] set_settle;
    logic        [CW-1:0] set_loss;

    modport master (
        output set_lo, set_hi, set_min, set_max, set_step,
        output set_div, set_settle, set_loss
    );

    modport slave (
        input set_lo, set_hi, set_min, set_max, set_step,
        input set_div, set_settle, set_loss
    );
endinterface

`default_nettype wire

// File: rtl/red_pitaya_lock_ctrl.sv
// ----------------------------------------------------------------------------
// red_pitaya_lock_ctrl : sweep / capture / lock / relock sequencer for one PID
// Optional: LOCK_CTRL_RAILED_RELOCK_EN (railed PID output counts as lock loss)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module red_pitaya_lock_ctrl #(
    parameter int DW = 14,
    parameter int CW = 24
) (
    input  wire logic                 clk_i,
    input  wire logic                 rstn_i,
    input  wire logic                 enable_i,
    input  wire logic signed [DW-1:0] mon_i,
    input  wire logic        [1:0]    railed_i,
    red_pitaya_lock_ctrl_if.slave     cfg,
    output logic signed [DW-1:0]      ramp_o,
    output logic                      sel_pid_o,
    output logic                      int_rst_o,
    output logic                      hold_o,
    output logic                      locked_o,
    output logic        [2:0]         state_o,
    output logic        [7:0]         relock_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SWEEP   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_LOCKED  = 3'd3
    } state_t;

    state_t               state_q, state_d;
    logic signed [DW-1:0] ramp_q, ramp_d;
    logic                 dir_dn_q, dir_dn_d;
    logic        [CW-1:0] div_q, div_d;
    logic        [CW-1:0] settle_q, settle_d;
    logic        [CW-1:0] loss_q, loss_d;
    logic        [7:0]    relock_q, relock_d;
    logic                 en_q;
    logic                 sel_q, sel_d;
    logic                 int_rst_q, int_rst_d;
    logic                 hold_q, hold_d;
    logic                 locked_q, locked_d;

    logic                 in_win;
    logic                 lock_ok;
    logic signed [DW+1:0] sum_up, sum_dn, min_x, max_x;
    logic signed [DW-1:0] ramp_step;
    logic                 dir_step;
    logic        [CW:0]   settle_inc, loss_inc;

    // An empty window (lo > hi) can never be satisfied by these two compares.
    assign in_win = ($signed(mon_i) >= $signed(cfg.set_lo)) &&
                    ($signed(mon_i) <= $signed(cfg.set_hi));

`ifdef LOCK_CTRL_RAILED_RELOCK_EN
    assign lock_ok = in_win && (railed_i == 2'b00);
`else
    logic railed_unused;
    assign railed_unused = ^railed_i;
    assign lock_ok       = in_win;
`endif

    // Two guard bits keep the sum exact for any step/ramp combination.
    assign min_x  = {{2{cfg.set_min[DW-1]}}, cfg.set_min};
    assign max_x  = {{2{cfg.set_max[DW-1]}}, cfg.set_max};
    assign sum_up = {{2{ramp_q[DW-1]}}, ramp_q} + $signed({2'b00, cfg.set_step});
    assign sum_dn = {{2{ramp_q[DW-1]}}, ramp_q} - $signed({2'b00, cfg.set_step});

    assign settle_inc = {1'b0, settle_q} + (CW+1)'(1);
    assign loss_inc   = {1'b0, loss_q} + (CW+1)'(1);

    always_comb begin
        ramp_step = ramp_q;
        dir_step  = dir_dn_q;
        if ($signed(cfg.set_min) >= $signed(cfg.set_max)) begin
            ramp_step = cfg.set_min;
        end else if (!dir_dn_q) begin
            if (sum_up >= max_x) begin
                ramp_step = cfg.set_max;
                dir_step  = 1'b1;
            end else begin
                ramp_step = sum_up[DW-1:0];
            end
        end else begin
            if (sum_dn <= min_x) begin
                ramp_step = cfg.set_min;
                dir_step  = 1'b0;
            end else begin
                ramp_step = sum_dn[DW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ramp_d   = ramp_q;
        dir_dn_d = dir_dn_q;
        div_d    = div_q;
        settle_d = settle_q;
        loss_d   = loss_q;
        relock_d = relock_q;

        if (enable_i && !en_q) begin
            relock_d = 8'd0;
        end

        if (!enable_i) begin
            state_d  = ST_IDLE;
            ramp_d   = '0;
            dir_dn_d = 1'b0;
            div_d    = '0;
            settle_d = '0;
            loss_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SWEEP;
                    ramp_d   = cfg.set_min;
                    dir_dn_d = 1'b0;
                    div_d    = '0;
                end
                ST_SWEEP: begin
                    if (in_win) begin
                        state_d  = ST_CAPTURE;
                        div_d    = '0;
                        settle_d = '0;
                    end else if (div_q >= cfg.set_div) begin
                        div_d    = '0;
                        ramp_d   = ramp_step;
                        dir_dn_d = dir_step;
                    end else begin
                        div_d    = div_q + CW'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (!in_win) begin
                        state_d  = ST_SWEEP;
                        settle_d = '0;
                        div_d    = '0;
                    end else if (settle_inc >= {1'b0, cfg.set_settle}) begin
                        state_d  = ST_LOCKED;
                        settle_d = '0;
                        loss_d   = '0;
                    end else begin
                        settle_d = settle_inc[CW-1:0];
                    end
                end
                ST_LOCKED: begin
                    if (lock_ok) begin
                        loss_d = '0;
                    end else if (loss_inc >= {1'b0, cfg.set_loss}) begin
                        state_d = ST_SWEEP;
                        loss_d  = '0;
                        div_d   = '0;
                        if (relock_q != 8'hFF) begin
                            relock_d = relock_q + 8'd1;
                        end
                    end else begin
                        loss_d = loss_inc[CW-1:0];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs follow the next state so they switch on the same edge.
        sel_d     = (state_d == ST_CAPTURE) || (state_d == ST_LOCKED);
        int_rst_d = (state_d == ST_IDLE) || (state_d == ST_SWEEP);
        locked_d  = (state_d == ST_LOCKED);
        hold_d    = (state_d == ST_LOCKED) && (loss_d != '0);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            ramp_q    <= '0;
            dir_dn_q  <= 1'b0;
            div_q     <= '0;
            settle_q  <= '0;
            loss_q    <= '0;
            relock_q  <= 8'd0;
            en_q      <= 1'b0;
            sel_q     <= 1'b0;
            int_rst_q <= 1'b1;
            hold_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ramp_q    <= ramp_d;
            dir_dn_q  <= dir_dn_d;
            div_q     <= div_d;
            settle_q  <= settle_d;
            loss_q    <= loss_d;
            relock_q  <= relock_d;
            en_q      <= enable_i;
            sel_q     <= sel_d;
            int_rst_q <= int_rst_d;
            hold_q    <= hold_d;
            locked_q  <= locked_d;
        end
    end

    assign ramp_o       = ramp_q;
    assign sel_pid_o    = sel_q;
    assign int_rst_o    = int_rst_q;
    assign hold_o       = hold_q;
    assign locked_o     = locked_q;
    assign state_o      = state_q;
    assign relock_cnt_o = relock_q;

endmodule

`default_nettype wire

// File: tb/tb_red_pitaya_lock_ctrl.sv
// ----------------------------------------------------------------------------
// tb_red_pitaya_lock_ctrl : directed self-checking bench for red_pitaya_lock_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_red_pitaya_lock_ctrl;

    localparam int DW = 14;
    localparam int CW = 24;

    logic                 clk;
    logic                 rstn;
    logic                 enable;
    logic signed [DW-1:0] mon;
    logic        [1:0]    railed;
    logic signed [DW-1:0] ramp;
    logic                 sel_pid, int_rst, hold, locked;
    logic        [2:0]    state;
    logic        [7:0]    relock_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    red_pitaya_lock_ctrl_if #(.DW(DW), .CW(CW)) cfg_if ();

    red_pitaya_lock_ctrl #(.DW(DW), .CW(CW)) u_dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .enable_i     (enable),
        .mon_i        (mon),
        .railed_i     (railed),
        .cfg          (cfg_if),
        .ramp_o       (ramp),
        .sel_pid_o    (sel_pid),
        .int_rst_o    (int_rst),
        .hold_o       (hold),
        .locked_o     (locked),
        .state_o      (state),
        .relock_cnt_o (relock_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int exp_ramp;

        rstn   = 1'b0;
        enable = 1'b0;
        mon    = '0;
        railed = 2'b00;
        cfg_if.set_lo     = 14'sd5000;
        cfg_if.set_hi     = 14'sd6000;
        cfg_if.set_min    = -14'sd100;
        cfg_if.set_max    = 14'sd100;
        cfg_if.set_step   = 14'd10;
        cfg_if.set_div    = 24'd1;
        cfg_if.set_settle = 24'd4;
        cfg_if.set_loss   = 24'd3;

        repeat (3) tick();
        check_eq("rst_state",   state, 0);
        check_eq("rst_ramp",    ramp, 0);
        check_eq("rst_int_rst", int_rst, 1);
        check_eq("rst_sel",     sel_pid, 0);
        check_eq("rst_hold",    hold, 0);
        check_eq("rst_locked",  locked, 0);
        check_eq("rst_relock",  relock_cnt, 0);

        rstn = 1'b1;
        tick();
        check_eq("idle_disabled", state, 0);

        // Sweep: -100 up to 100 then back down, one step every 2 cycles
        enable = 1'b1;
        tick();
        check_eq("sweep_start_state", state, 1);
        check_eq("sweep_start_ramp",  ramp, -100);
        for (int i = 1; i <= 54; i++) begin
            tick();
            k = i / 2;
            exp_ramp = (k <= 20) ? (-100 + 10 * k) : (100 - 10 * (k - 20));
            check_eq("sweep_ramp",    ramp, exp_ramp);
            check_eq("sweep_state",   state, 1);
            check_eq("sweep_int_rst", int_rst, 1);
        end

        // Capture at ramp=30, settle=4
        mon = 14'sd5500;
        tick();
        check_eq("cap_state",   state, 2);
        check_eq("cap_sel",     sel_pid, 1);
        check_eq("cap_int_rst", int_rst, 0);
        check_eq("cap_ramp",    ramp, 30);
        repeat (3) tick();
        check_eq("cap_settling", state, 2);
        tick();
        check_eq("lock_state",  state, 3);
        check_eq("lock_locked", locked, 1);
        check_eq("lock_sel",    sel_pid, 1);
        check_eq("lock_hold0",  hold, 0);

        // Brief dropout holds the PID, then recovers
        mon = '0;
        tick();
        check_eq("drop1_hold",  hold, 1);
        check_eq("drop1_state", state, 3);
        tick();
        check_eq("drop2_hold",  hold, 1);
        mon = 14'sd5500;
        tick();
        check_eq("recover_hold",  hold, 0);
        check_eq("recover_state", state, 3);

        // Sustained loss triggers relock
        mon = '0;
        tick();
        tick();
        check_eq("loss2_state", state, 3);
        tick();
        check_eq("loss_state",   state, 1);
        check_eq("loss_relock",  relock_cnt, 1);
        check_eq("loss_locked",  locked, 0);
        check_eq("loss_int_rst", int_rst, 1);
        check_eq("loss_ramp",    ramp, 30);

        // Capture aborted on the second cycle
        mon = 14'sd5500;
        tick();
        check_eq("cap2_state", state, 2);
        tick();
        check_eq("cap2_hold_state", state, 2);
        mon = '0;
        tick();
        check_eq("abort_state",   state, 1);
        check_eq("abort_int_rst", int_rst, 1);
        check_eq("abort_ramp",    ramp, 30);
        tick();
        check_eq("resume_ramp_a", ramp, 30);
        tick();
        check_eq("resume_ramp_b", ramp, 20);

        // settle=0 locks on the first capture cycle
        cfg_if.set_settle = 24'd0;
        mon = 14'sd5500;
        tick();
        check_eq("s0_cap", state, 2);
        tick();
        check_eq("s0_lock", state, 3);

        // Disable and re-enable
        enable = 1'b0;
        tick();
        check_eq("dis_state",   state, 0);
        check_eq("dis_ramp",    ramp, 0);
        check_eq("dis_int_rst", int_rst, 1);
        check_eq("dis_locked",  locked, 0);
        check_eq("dis_relock",  relock_cnt, 1);
        enable = 1'b1;
        tick();
        check_eq("reen_state",  state, 1);
        check_eq("reen_ramp",   ramp, -100);
        check_eq("reen_relock", relock_cnt, 0);

        // Empty window never captures
        cfg_if.set_lo = 14'sd6000;
        cfg_if.set_hi = 14'sd5000;
        repeat (3) tick();
        check_eq("empty_win_state", state, 1);
        cfg_if.set_lo = 14'sd5000;
        cfg_if.set_hi = 14'sd6000;
        tick();
        tick();
        check_eq("relock_again", state, 3);

        // Railed PID while in window
        railed = 2'b10;
        repeat (3) tick();
`ifdef LOCK_CTRL_RAILED_RELOCK_EN
        check_eq("railed_state", state, 1);
`else
        check_eq("railed_state", state, 3);
        check_eq("railed_hold",  hold, 0);
`endif
        railed = 2'b00;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        check_eq("sat_start_relock", relock_cnt, 0);

        // Loss-event counter saturates at 255
        cfg_if.set_loss = 24'd0;
        for (int i = 0; i < 260; i++) begin
            tick();
            tick();
            mon = '0;
            tick();
            mon = 14'sd5500;
            if (i == 0) check_eq("sat_first", relock_cnt, 1);
        end
        check_eq("sat_relock", relock_cnt, 255);

        // min >= max pins the ramp at min
        mon = '0;
        cfg_if.set_min = 14'sd50;
        cfg_if.set_max = 14'sd50;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        repeat (4) tick();
        check_eq("pin_ramp",  ramp, 50);
        check_eq("pin_state", state, 1);

        // Asynchronous reset mid-capture
        cfg_if.set_min = -14'sd100;
        cfg_if.set_max = 14'sd100;
        cfg_if.set_settle = 24'd4;
        mon = 14'sd5500;
        tick();
        check_eq("pre_arst_state", state, 2);
        rstn = 1'b0;
        #1;
        check_eq("arst_state",   state, 0);
        check_eq("arst_int_rst", int_rst, 1);
        check_eq("arst_sel",     sel_pid, 0);
        check_eq("arst_ramp",    ramp, 0);
        #20;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
